// File: rtl/bp_update_unit.sv
// Commit-side branch-outcome sender: queues committed {pc, taken} pairs and drains
// one predictor update per cycle, while counting committed branches and mispredictions.
module bp_update_unit #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              commit_valid,
  output logic              commit_ready,
  input  logic [ADDR_W-1:0] commit_pc,
  input  logic              commit_taken,
  input  logic              commit_pred,
  output logic              ena_to_bp,
  output logic              hit_to_bp,
  output logic [ADDR_W-1:0] pc_to_bp,
  input  logic              stat_clear,
  output logic [CNT_W-1:0]  stat_branches,
  output logic [CNT_W-1:0]  stat_mispred
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] fifo_pc    [DEPTH];
  logic              fifo_taken [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic              push;
  logic              pop;

  function automatic logic [CNT_W-1:0] next_stat(input logic [CNT_W-1:0] cur,
                                                 input logic inc);
    return inc ? cur + CNT_W'(1) : cur;
  endfunction

  // Ready depends only on registered occupancy so the ROB sees no comb path back.
  assign commit_ready = (count != FULL_CNT);
  assign push         = commit_valid && commit_ready;
  assign pop          = (count != '0);

  // Storage holds data only; validity is tracked by count, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]    <= commit_pc;
      fifo_taken[wr_ptr] <= commit_taken;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Predictor never stalls: head goes out every cycle the queue is non-empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ena_to_bp <= 1'b0;
      hit_to_bp <= 1'b0;
      pc_to_bp  <= '0;
    end else if (pop) begin
      ena_to_bp <= 1'b1;
      hit_to_bp <= fifo_taken[rd_ptr];
      pc_to_bp  <= fifo_pc[rd_ptr];
    end else begin
      ena_to_bp <= 1'b0;
    end
  end

  // Clear wins over a concurrent accepted push, which then goes uncounted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_branches <= '0;
      stat_mispred  <= '0;
    end else if (stat_clear) begin
      stat_branches <= '0;
      stat_mispred  <= '0;
    end else begin
      stat_branches <= next_stat(stat_branches, push);
      stat_mispred  <= next_stat(stat_mispred, push && (commit_pred != commit_taken));
    end
  end

endmodule
